// File: rtl/twiddle_requant_stage.sv
// Requantises the CSD twiddle multiplier's complex product back to NBITS (round half up, saturate),
// buffers it in a 2-entry valid/ready FIFO and owns the multiplier's twiddle-cycle select counter.
module twiddle_requant_stage #(
    parameter int NBITS      = 12,
    parameter int NBITScoeff = 11,
    parameter int NBITS_out  = NBITS + NBITScoeff + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*NBITS_out-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [1:0]             csd_num_ciclo,
    input  logic                   cnt_clr,
    output logic [2*NBITS-1:0]     out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   sat_flag,
    input  logic                   sat_clr
);

    localparam int SHIFT = NBITScoeff - 2;
    localparam int W     = NBITS_out + 1;
    localparam logic signed [W-1:0] HALF = W'(1 << (SHIFT - 1));
    localparam logic signed [W-1:0] MAXV = W'((1 << (NBITS - 1)) - 1);
    localparam logic signed [W-1:0] MINV = W'(-(1 << (NBITS - 1)));

    // Returns {saturated, value}; the extra guard bit keeps the rounding add from overflowing.
    function automatic logic [NBITS:0] requant(input logic [NBITS_out-1:0] x);
        logic signed [W-1:0] sum;
        logic signed [W-1:0] t;
        sum = $signed({x[NBITS_out-1], x}) + HALF;
        t   = sum >>> SHIFT;
        if (t > MAXV)
            requant = {1'b1, MAXV[NBITS-1:0]};
        else if (t < MINV)
            requant = {1'b1, MINV[NBITS-1:0]};
        else
            requant = {1'b0, t[NBITS-1:0]};
    endfunction

    logic [2*NBITS-1:0] wr_data;
    logic [1:0]         sat_vec;
    logic [NBITS:0]     rq [2];

    // Component 0 is imag (low half), component 1 is real (high half).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_comp
            assign rq[gi] = requant(in_data[gi*NBITS_out +: NBITS_out]);
            assign wr_data[gi*NBITS +: NBITS] = rq[gi][NBITS-1:0];
            assign sat_vec[gi] = rq[gi][NBITS];
        end
    endgenerate

    logic [2*NBITS-1:0] mem_reg [2];
    logic               wr_ptr_reg, rd_ptr_reg;
    logic [1:0]         count_reg, count_next;
    logic [1:0]         cnt_reg, cnt_next;
    logic               sat_reg, sat_next;
    logic               acc, pop;

    assign in_ready      = (count_reg < 2'd2);
    assign out_valid     = (count_reg != 2'd0);
    assign out_data      = mem_reg[rd_ptr_reg];
    assign csd_num_ciclo = cnt_reg;
    assign sat_flag      = sat_reg;
    assign acc           = in_valid & in_ready;
    assign pop           = out_valid & out_ready;

    always_comb begin
        count_next = count_reg;
        if (acc && !pop)
            count_next = count_reg + 2'd1;
        else if (pop && !acc)
            count_next = count_reg - 2'd1;

        cnt_next = cnt_reg;
        if (cnt_clr)
            cnt_next = 2'd0;
        else if (acc)
            cnt_next = cnt_reg + 2'd1;

        // A new saturation outranks a simultaneous clear.
        sat_next = sat_reg;
        if (acc && (sat_vec != 2'b00))
            sat_next = 1'b1;
        else if (sat_clr)
            sat_next = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++)
                mem_reg[i] <= '0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
            cnt_reg    <= 2'd0;
            sat_reg    <= 1'b0;
        end else begin
            if (acc) begin
                mem_reg[wr_ptr_reg] <= wr_data;
                wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (pop)
                rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_next;
            cnt_reg   <= cnt_next;
            sat_reg   <= sat_next;
        end
    end

endmodule

// File: tb/tb_twiddle_requant_stage.sv
// Scoreboard bench for twiddle_requant_stage: expected words queued on accept, compared on pop.
module tb_twiddle_requant_stage;

    localparam int NBITS     = 12;
    localparam int NBITS_OUT = 24;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [2*NBITS_OUT-1:0] in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [1:0]             csd_num_ciclo;
    logic                   cnt_clr;
    logic [2*NBITS-1:0]     out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   sat_flag;
    logic                   sat_clr;

    int vectors = 0;
    int miscompares = 0;
    logic [2*NBITS-1:0] sb_q[$];

    twiddle_requant_stage dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .csd_num_ciclo(csd_num_ciclo), .cnt_clr(cnt_clr), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .sat_flag(sat_flag), .sat_clr(sat_clr)
    );

    always #5 clk = ~clk;

    // Independent reference: floor((x + 256) / 512), clamped to 12-bit signed.
    function automatic int ref_q(input int x);
        int t;
        t = (x + 256) >>> 9;
        if (t > 2047) t = 2047;
        if (t < -2048) t = -2048;
        return t;
    endfunction

    function automatic logic [2*NBITS-1:0] ref_word(input int re, input int im);
        logic [11:0] r, i;
        r = 12'(ref_q(re));
        i = 12'(ref_q(im));
        return {r, i};
    endfunction

    // Monitor: pops are compared before pushes, both on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                vectors++;
                if (sb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL pop_underflow: out_data=%h with no sample expected", out_data);
                end else begin
                    logic [2*NBITS-1:0] exp_w;
                    exp_w = sb_q.pop_front();
                    if (out_data !== exp_w) begin
                        miscompares++;
                        $display("FAIL out_data: got %h expected %h", out_data, exp_w);
                    end else
                        $display("pop  out_data=%h ok", out_data);
                end
            end
            if (in_valid && in_ready)
                sb_q.push_back(ref_word($signed(in_data[47:24]), $signed(in_data[23:0])));
        end
    end

    task automatic set_in(input int re, input int im);
        in_data = {24'(re), 24'(im)};
        in_valid = 1'b1;
    endtask

    // Present a sample and hold it until it is accepted; returns at posedge+1.
    task automatic send(input int re, input int im);
        logic accepted;
        set_in(re, im);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk); #1;
            if (accepted) begin
                in_valid = 1'b0;
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL send_timeout: in_ready stayed %b expected 1", in_ready);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && sb_q.size() != 0; n++) @(posedge clk);
        #1;
        vectors++;
        if (sb_q.size() != 0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain: %0d pending out_valid=%b expected 0/0", sb_q.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; cnt_clr = 1'b0; sat_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 ||
            csd_num_ciclo !== 2'd0 || sat_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: rdy=%b vld=%b data=%h cnt=%0d sat=%b expected 1 0 0 0 0",
                     in_ready, out_valid, out_data, csd_num_ciclo, sat_flag);
        end else $display("reset state ok");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        send(51200, -51200);
        vectors++;
        if (out_valid !== 1'b1 || sat_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_latency: out_valid=%b sat=%b expected 1 0", out_valid, sat_flag);
        end else $display("basic sample out_valid after 1 edge ok");
        drain();
    endtask

    task automatic test_rounding();
        int vals[5] = '{255, 256, -256, -257, 767};
        foreach (vals[k]) send(vals[k], vals[k]);
        drain();
        vectors++;
        if (sat_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL round_sat: sat_flag=%b expected 0", sat_flag);
        end
    endtask

    task automatic test_saturation();
        send(1048576, -1049088);
        vectors++;
        if (sat_flag !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_set: sat_flag=%b expected 1", sat_flag);
        end else $display("sat_flag set ok");
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        vectors++;
        if (sat_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_clear: sat_flag=%b expected 0", sat_flag);
        end else $display("sat_flag cleared ok");
        sat_clr = 1'b1;
        send(-2000000, 5);
        sat_clr = 1'b0;
        vectors++;
        if (sat_flag !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_set_wins: sat_flag=%b expected 1", sat_flag);
        end else $display("set beats clear ok");
        drain();
    endtask

    task automatic test_backpressure();
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        out_ready = 1'b0;
        set_in(1000, 2000);            // A
        @(posedge clk); #1;
        set_in(-3000, 4000);           // B
        @(posedge clk); #1;
        set_in(70000, -70000);         // C
        vectors++;
        if (in_ready !== 1'b0 || csd_num_ciclo !== 2'd2) begin
            miscompares++;
            $display("FAIL bp_full: in_ready=%b cnt=%0d expected 0 2", in_ready, csd_num_ciclo);
        end else $display("full after two accepts ok");
        @(posedge clk); #1;
        vectors++;
        if (in_ready !== 1'b0 || csd_num_ciclo !== 2'd2 || out_data !== ref_word(1000, 2000)) begin
            miscompares++;
            $display("FAIL bp_hold: rdy=%b cnt=%0d head=%h expected 0 2 %h",
                     in_ready, csd_num_ciclo, out_data, ref_word(1000, 2000));
        end
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_no_comb_ready: in_ready=%b expected 0", in_ready);
        end
        @(posedge clk); #1;            // A popped, C still waiting
        @(posedge clk); #1;            // B popped, C accepted
        in_valid = 1'b0;
        vectors++;
        if (csd_num_ciclo !== 2'd3) begin
            miscompares++;
            $display("FAIL bp_counter: cnt=%0d expected 3", csd_num_ciclo);
        end else $display("counter advanced on 3 accepts ok");
        drain();
    endtask

    task automatic test_back_to_back();
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_in(i * 512, -i * 512);
            @(negedge clk);
            vectors++;
            if (csd_num_ciclo !== 2'(i % 4)) begin
                miscompares++;
                $display("FAIL b2b_counter[%0d]: cnt=%0d expected %0d", i, csd_num_ciclo, i % 4);
            end else $display("accept %0d cnt=%0d ok", i, csd_num_ciclo);
            @(posedge clk); #1;
        end
        set_in(9, 9);
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        in_valid = 1'b0;
        vectors++;
        if (csd_num_ciclo !== 2'd0) begin
            miscompares++;
            $display("FAIL clr_priority: cnt=%0d expected 0", csd_num_ciclo);
        end else $display("cnt_clr priority ok");
        drain();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        send(1048576, 0);
        send(512, 512);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        sb_q.delete();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || csd_num_ciclo !== 2'd0 ||
            sat_flag !== 1'b0 || out_data !== '0) begin
            miscompares++;
            $display("FAIL async_reset: vld=%b rdy=%b cnt=%0d sat=%b data=%h expected 0 1 0 0 0",
                     out_valid, in_ready, csd_num_ciclo, sat_flag, out_data);
        end else $display("async reset ok");
        @(negedge clk) rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(-51200, 51200);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_latency: out_valid=%b expected 1", out_valid);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
